// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory arbiter (imem_arbiter).
// The optional boot lock is selected by defining IMEM_BOOT_LOCK_EN.
package imem_pkg;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [31:0] RV32I_NOP      = 32'h0000_0013;
  localparam int          DEFAULT_ADDR_W = 10;

endpackage

// File: rtl/imem_starve_cnt.sv
// Loader starvation counter: counts consecutive denied loader cycles, saturating at MAX_WAIT.
// Zero latency on force_l (combinational from the count); no backpressure of its own.
module imem_starve_cnt #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic l_req,
  input  logic l_gnt,
  output logic force_l
);

  logic [3:0] wait_cnt_d;
  logic [3:0] wait_cnt_q;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (rst || !l_req || l_gnt) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q != 4'(MAX_WAIT)) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    wait_cnt_q <= wait_cnt_d;
  end

  assign force_l = (wait_cnt_q == 4'(MAX_WAIT)) && l_req;

endmodule

// File: rtl/imem_arbiter.sv
// Arbitrates fetch (fixed priority) and loader onto one SRAM port; reads return 1 cycle after grant,
// losers retry via the combinational gnt. Define IMEM_BOOT_LOCK_EN to hold fetch off until boot_done.
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [31:0]       f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [31:0]       f_rdata,
  output logic              f_err,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [31:0]       l_addr,
  input  logic [31:0]       l_wdata,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [31:0]       l_rdata,
  input  logic              boot_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_e state;
  logic   force_l;
  logic   f_bad;
  logic   l_bad;

`ifdef IMEM_BOOT_LOCK_EN
  state_e state_d;
  state_e state_q;

  always_comb begin
    state_d = state_q;
    if (rst) begin
      state_d = BOOT;
    end else if ((state_q == BOOT) && boot_done) begin
      state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
  end

  assign state = state_q;
`else
  logic unused_boot_done;

  assign state            = RUN;
  assign unused_boot_done = boot_done;
`endif

  assign f_bad = (f_addr[1:0] != 2'b00) || (f_addr[31:ADDR_W+2] != '0);
  assign l_bad = (l_addr[1:0] != 2'b00) || (l_addr[31:ADDR_W+2] != '0);

  imem_starve_cnt #(
    .MAX_WAIT(MAX_WAIT)
  ) u_starve (
    .clk    (clk),
    .rst    (rst),
    .l_req  (l_req),
    .l_gnt  (l_gnt),
    .force_l(force_l)
  );

  always_comb begin
    f_gnt = 1'b0;
    l_gnt = 1'b0;
    if (!rst) begin
      if (state == BOOT) begin
        l_gnt = l_req;
      end else if (force_l) begin
        l_gnt = 1'b1;
      end else begin
        f_gnt = f_req;
        l_gnt = l_req && !f_req;
      end
    end
  end

  // Bad addresses are still granted so the requester moves on, but never reach the SRAM.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (f_gnt && !f_bad) begin
      mem_en   = 1'b1;
      mem_addr = f_addr[ADDR_W+1:2];
    end else if (l_gnt && !l_bad) begin
      mem_en    = 1'b1;
      mem_we    = l_we;
      mem_addr  = l_addr[ADDR_W+1:2];
      mem_wdata = l_we ? l_wdata : 32'd0;
    end
  end

  logic f_pend_d, f_pend_q;
  logic f_nop_d,  f_nop_q;
  logic l_pend_d, l_pend_q;
  logic l_zero_d, l_zero_q;

  // Grants are already forced low under rst, so a response never launches from a reset cycle.
  always_comb begin
    f_pend_d = f_gnt;
    f_nop_d  = f_gnt && f_bad;
    l_pend_d = l_gnt && !l_we;
    l_zero_d = l_gnt && !l_we && l_bad;
  end

  always_ff @(posedge clk) begin
    f_pend_q <= f_pend_d;
    f_nop_q  <= f_nop_d;
    l_pend_q <= l_pend_d;
    l_zero_q <= l_zero_d;
  end

  assign f_rvalid = f_pend_q;
  assign f_err    = f_nop_q;
  assign f_rdata  = f_nop_q ? RV32I_NOP : (f_pend_q ? mem_rdata : 32'd0);
  assign l_rvalid = l_pend_q;
  assign l_rdata  = (l_pend_q && !l_zero_q) ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed scenarios plus randomized traffic against a
// cycle-level reference model; honours IMEM_BOOT_LOCK_EN when defined.
`timescale 1ns/1ps
module tb_imem_arbiter;
  import imem_pkg::*;

  localparam int AW    = 10;
  localparam int MW    = 4;
  localparam int WORDS = 1 << AW;
`ifdef IMEM_BOOT_LOCK_EN
  localparam bit BOOT_LOCK = 1'b1;
`else
  localparam bit BOOT_LOCK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          f_req, f_gnt, f_rvalid, f_err;
  logic [31:0]   f_addr, f_rdata;
  logic          l_req, l_we, l_gnt, l_rvalid;
  logic [31:0]   l_addr, l_wdata, l_rdata;
  logic          boot_done;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  imem_arbiter #(.ADDR_W(AW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata), .f_err(f_err),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata), .l_gnt(l_gnt),
    .l_rvalid(l_rvalid), .l_rdata(l_rdata), .boot_done(boot_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Synchronous single-port SRAM
  logic [31:0] sram [0:WORDS-1];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      else        mem_rdata <= sram[mem_addr];
    end
  end

  // Reference model state
  logic [31:0] ref_mem [0:WORDS-1];
  int          m_wait;
  bit          m_boot;
  bit          e_fg, e_lg, e_fv, e_fe, e_lv;
  logic [31:0] e_fd, e_ld;
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic bit is_bad(logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> (AW + 2)) != 0);
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    int r;
    a = {20'd0, 10'($urandom_range(63)), 2'b00};
    r = $urandom_range(99);
    if (r < 6)       a[1:0]  = 2'($urandom_range(3, 1));
    else if (r < 12) a[31:12] = 20'($urandom_range(1048575, 1));
    return a;
  endfunction

  task automatic predict();
    e_fg = 1'b0;
    e_lg = 1'b0;
    if (!rst) begin
      if (m_boot)                      e_lg = l_req;
      else if (l_req && m_wait >= MW)  e_lg = 1'b1;
      else begin
        e_fg = f_req;
        e_lg = l_req && !f_req;
      end
    end
  endtask

  task automatic tick();
    predict();
    @(posedge clk);
    if (rst) begin
      e_fv = 0; e_lv = 0; e_fe = 0; e_fd = '0; e_ld = '0;
      m_wait = 0;
      m_boot = BOOT_LOCK;
    end else begin
      e_fv = e_fg;
      e_fe = e_fg && is_bad(f_addr);
      e_fd = !e_fg ? 32'd0 : (is_bad(f_addr) ? 32'h0000_0013 : ref_mem[f_addr[AW+1:2]]);
      e_lv = e_lg && !l_we;
      e_ld = (e_lv && !is_bad(l_addr)) ? ref_mem[l_addr[AW+1:2]] : 32'd0;
      if (e_lg && l_we && !is_bad(l_addr)) ref_mem[l_addr[AW+1:2]] = l_wdata;
      if (l_req && !e_lg) m_wait = (m_wait < MW) ? m_wait + 1 : MW;
      else                m_wait = 0;
      if (m_boot && boot_done) m_boot = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1; f_req = 0; l_req = 0; l_we = 0; boot_done = 0;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic enter_run();
    if (BOOT_LOCK) begin
      boot_done = 1;
      tick();
      boot_done = 0;
    end
  endtask

  task automatic test_reset();
    rst = 1; f_req = 1; f_addr = 32'h0; l_req = 1; l_we = 1; l_addr = 32'h20; l_wdata = 32'h1234; boot_done = 0;
    #1;
    n_tests++;
    if (f_gnt !== 1'b0 || l_gnt !== 1'b0 || mem_en !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
      n_fail++;
      $display("FAIL reset_drive: f_gnt=%b l_gnt=%b mem_en=%b mem_we=%b mem_addr=%h mem_wdata=%h, required all zero",
               f_gnt, l_gnt, mem_en, mem_we, mem_addr, mem_wdata);
    end
    tick();
    f_req = 0; l_req = 0; l_we = 0;
    tick();
    rst = 0;
    #1;
    n_tests++;
    if (f_rvalid !== 1'b0 || l_rvalid !== 1'b0 || f_rdata !== 32'd0 || l_rdata !== 32'd0 || f_err !== 1'b0 ||
        dut.u_starve.wait_cnt_q !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_values: f_rvalid=%b l_rvalid=%b f_rdata=%h l_rdata=%h f_err=%b wait_cnt=%0d, required all zero",
               f_rvalid, l_rvalid, f_rdata, l_rdata, f_err, dut.u_starve.wait_cnt_q);
    end
    f_req = 1; f_addr = 32'h4;
    #1;
    n_tests++;
    if (f_gnt !== !BOOT_LOCK) begin
      n_fail++;
      $display("FAIL reset_state: f_gnt=%b required %b", f_gnt, !BOOT_LOCK);
    end
    f_req = 0;
    #1;
  endtask

  task automatic test_boot_lock();
    do_reset();
    if (BOOT_LOCK) begin
      f_req = 1; f_addr = 32'h10;
      #1;
      n_tests++;
      if (f_gnt !== 1'b0) begin n_fail++; $display("FAIL boot_hold: f_gnt=%b required 0", f_gnt); end
      tick();
      l_req = 1; l_we = 1; l_addr = 32'h10; l_wdata = 32'hDEADBEEF; boot_done = 1;
      #1;
      n_tests++;
      if (f_gnt !== 1'b0 || l_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 10'd4 || mem_wdata !== 32'hDEADBEEF) begin
        n_fail++;
        $display("FAIL boot_write: f_gnt=%b l_gnt=%b mem_en=%b mem_we=%b mem_addr=%h mem_wdata=%h, required 0 1 1 1 004 deadbeef",
                 f_gnt, l_gnt, mem_en, mem_we, mem_addr, mem_wdata);
      end
      tick();
      l_req = 0; l_we = 0; boot_done = 0;
    end else begin
      f_req = 0; l_req = 1; l_we = 1; l_addr = 32'h10; l_wdata = 32'hDEADBEEF; boot_done = 1;
      #1;
      n_tests++;
      if (l_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 10'd4) begin
        n_fail++;
        $display("FAIL run_write: l_gnt=%b mem_we=%b mem_addr=%h, required 1 1 004", l_gnt, mem_we, mem_addr);
      end
      tick();
      l_req = 0; l_we = 0; f_req = 1; f_addr = 32'h10;
    end
    #1;
    n_tests++;
    if (f_gnt !== 1'b1 || mem_en !== 1'b1 || mem_addr !== 10'd4) begin
      n_fail++;
      $display("FAIL first_run_fetch: f_gnt=%b mem_en=%b mem_addr=%h, required 1 1 004", f_gnt, mem_en, mem_addr);
    end
    tick();
    f_req = 0; boot_done = 0;
    #1;
    n_tests++;
    if (f_rvalid !== 1'b1 || f_rdata !== 32'hDEADBEEF || f_err !== 1'b0) begin
      n_fail++;
      $display("FAIL boot_readback: f_rvalid=%b f_rdata=%h f_err=%b, required 1 deadbeef 0", f_rvalid, f_rdata, f_err);
    end
  endtask

  task automatic test_starvation();
    bit exp_f;
    do_reset();
    enter_run();
    f_req = 1; f_addr = 32'h0; l_req = 1; l_we = 0; l_addr = 32'h20;
    for (int c = 0; c < 7; c++) begin
      exp_f = (c != MW);
      #1;
      n_tests++;
      if (f_gnt !== exp_f || l_gnt !== !exp_f) begin
        n_fail++;
        $display("FAIL starve_cycle%0d: f_gnt=%b l_gnt=%b, required %b %b", c, f_gnt, l_gnt, exp_f, !exp_f);
      end
      if (c == MW + 1) begin
        n_tests++;
        if (dut.u_starve.wait_cnt_q !== 4'd0 || l_rvalid !== 1'b1 || l_rdata !== ref_mem[8] || f_rvalid !== 1'b0) begin
          n_fail++;
          $display("FAIL starve_after: wait_cnt=%0d l_rvalid=%b l_rdata=%h f_rvalid=%b, required 0 1 %h 0",
                   dut.u_starve.wait_cnt_q, l_rvalid, l_rdata, f_rvalid, ref_mem[8]);
        end
      end
      tick();
    end
    f_req = 0; l_req = 0;
  endtask

  task automatic test_bad_access();
    logic [31:0] bad_addrs [2] = '{32'h0000_0002, 32'h0000_1000};
    do_reset();
    enter_run();
    for (int i = 0; i < 2; i++) begin
      f_req = 1; f_addr = bad_addrs[i];
      #1;
      n_tests++;
      if (f_gnt !== 1'b1 || mem_en !== 1'b0) begin
        n_fail++;
        $display("FAIL bad_fetch_gnt %h: f_gnt=%b mem_en=%b, required 1 0", bad_addrs[i], f_gnt, mem_en);
      end
      tick();
      f_req = 0;
      #1;
      n_tests++;
      if (f_rvalid !== 1'b1 || f_rdata !== 32'h0000_0013 || f_err !== 1'b1) begin
        n_fail++;
        $display("FAIL bad_fetch_resp %h: f_rvalid=%b f_rdata=%h f_err=%b, required 1 00000013 1",
                 bad_addrs[i], f_rvalid, f_rdata, f_err);
      end
    end
    l_req = 1; l_we = 1; l_addr = 32'h0000_1004; l_wdata = 32'hCAFEF00D;
    #1;
    n_tests++;
    if (l_gnt !== 1'b1 || mem_en !== 1'b0 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_write: l_gnt=%b mem_en=%b mem_we=%b, required 1 0 0", l_gnt, mem_en, mem_we);
    end
    tick();
    l_we = 0; l_addr = 32'h0000_0003;
    #1;
    n_tests++;
    if (l_rvalid !== 1'b0 || l_gnt !== 1'b1 || mem_en !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_read_gnt: l_rvalid=%b l_gnt=%b mem_en=%b, required 0 1 0", l_rvalid, l_gnt, mem_en);
    end
    tick();
    l_addr = 32'h0000_0004;
    #1;
    n_tests++;
    if (l_rvalid !== 1'b1 || l_rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL bad_read_resp: l_rvalid=%b l_rdata=%h, required 1 00000000", l_rvalid, l_rdata);
    end
    tick();
    l_req = 0;
    #1;
    n_tests++;
    if (l_rvalid !== 1'b1 || l_rdata !== ref_mem[1]) begin
      n_fail++;
      $display("FAIL bad_write_dropped: l_rvalid=%b l_rdata=%h, required 1 %h", l_rvalid, l_rdata, ref_mem[1]);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    enter_run();
    for (int c = 0; c < 4; c++) begin
      f_req = (c < 3);
      f_addr = 32'(c * 4);
      #1;
      if (c < 3) begin
        n_tests++;
        if (f_gnt !== 1'b1 || mem_en !== 1'b1 || mem_addr !== 10'(c)) begin
          n_fail++;
          $display("FAIL b2b_gnt%0d: f_gnt=%b mem_en=%b mem_addr=%h, required 1 1 %h", c, f_gnt, mem_en, mem_addr, 10'(c));
        end
      end
      if (c > 0) begin
        n_tests++;
        if (f_rvalid !== 1'b1 || f_rdata !== ref_mem[c-1] || f_err !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_resp%0d: f_rvalid=%b f_rdata=%h f_err=%b, required 1 %h 0", c - 1, f_rvalid, f_rdata, f_err, ref_mem[c-1]);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    enter_run();
    f_req = 1; f_addr = 32'h8;
    #1;
    n_tests++;
    if (f_gnt !== 1'b1) begin n_fail++; $display("FAIL midrst_pre: f_gnt=%b required 1", f_gnt); end
    rst = 1;
    #1;
    n_tests++;
    if (f_gnt !== 1'b0 || mem_en !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_gnt: f_gnt=%b mem_en=%b, required 0 0", f_gnt, mem_en);
    end
    tick();
    rst = 0; f_req = 0;
    #1;
    n_tests++;
    if (f_rvalid !== 1'b0 || l_rvalid !== 1'b0 || f_rdata !== 32'd0 || l_rdata !== 32'd0 || f_err !== 1'b0 ||
        dut.u_starve.wait_cnt_q !== 4'd0) begin
      n_fail++;
      $display("FAIL midrst_out: f_rvalid=%b l_rvalid=%b f_rdata=%h l_rdata=%h f_err=%b wait_cnt=%0d, required all zero",
               f_rvalid, l_rvalid, f_rdata, l_rdata, f_err, dut.u_starve.wait_cnt_q);
    end
  endtask

  task automatic test_loader_read();
    do_reset();
    enter_run();
    f_req = 0; l_req = 1; l_we = 0; l_addr = 32'h20;
    #1;
    n_tests++;
    if (l_gnt !== 1'b1 || f_gnt !== 1'b0 || mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 10'd8) begin
      n_fail++;
      $display("FAIL lread_gnt: l_gnt=%b f_gnt=%b mem_en=%b mem_we=%b mem_addr=%h, required 1 0 1 0 008",
               l_gnt, f_gnt, mem_en, mem_we, mem_addr);
    end
    tick();
    l_req = 0;
    #1;
    n_tests++;
    if (l_rvalid !== 1'b1 || l_rdata !== ref_mem[8] || f_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL lread_resp: l_rvalid=%b l_rdata=%h f_rvalid=%b, required 1 %h 0", l_rvalid, l_rdata, f_rvalid, ref_mem[8]);
    end
  endtask

  task automatic test_random();
    bit f_hold, l_hold, e_men, e_mwe;
    logic [AW-1:0] e_maddr;
    int errs;
    f_hold = 0; l_hold = 0; errs = 0;
    do_reset();
    enter_run();
    for (int c = 0; c < 800; c++) begin
      rst = ($urandom_range(99) < 2);
      if (!f_hold) begin f_req = ($urandom_range(99) < 60); f_addr = rand_addr(); end
      if (!l_hold) begin
        l_req = ($urandom_range(99) < 50); l_we = 1'($urandom_range(1));
        l_addr = rand_addr(); l_wdata = $urandom();
      end
      boot_done = ($urandom_range(99) < 10);
      predict();
      e_men   = (e_fg && !is_bad(f_addr)) || (e_lg && !is_bad(l_addr));
      e_mwe   = e_lg && l_we && !is_bad(l_addr);
      e_maddr = e_fg ? f_addr[AW+1:2] : l_addr[AW+1:2];
      #1;
      n_tests++;
      if (f_gnt !== e_fg || l_gnt !== e_lg || mem_en !== e_men || mem_we !== e_mwe ||
          (e_men && mem_addr !== e_maddr) || (e_mwe && mem_wdata !== l_wdata) ||
          (!e_fg && !e_lg && (mem_addr !== '0 || mem_wdata !== '0))) begin
        n_fail++;
        if (errs++ < 10)
          $display("FAIL rand_gnt c%0d: f_gnt=%b l_gnt=%b mem_en=%b mem_we=%b mem_addr=%h, required %b %b %b %b %h",
                   c, f_gnt, l_gnt, mem_en, mem_we, mem_addr, e_fg, e_lg, e_men, e_mwe, e_maddr);
      end
      n_tests++;
      if (f_rvalid !== e_fv || l_rvalid !== e_lv || (e_fv && (f_rdata !== e_fd || f_err !== e_fe)) ||
          (e_lv && l_rdata !== e_ld) || (f_rvalid === 1'b1 && l_rvalid === 1'b1)) begin
        n_fail++;
        if (errs++ < 10)
          $display("FAIL rand_resp c%0d: f_rvalid=%b f_rdata=%h f_err=%b l_rvalid=%b l_rdata=%h, required %b %h %b %b %h",
                   c, f_rvalid, f_rdata, f_err, l_rvalid, l_rdata, e_fv, e_fd, e_fe, e_lv, e_ld);
      end
      f_hold = f_req && !e_fg && !rst;
      l_hold = l_req && !e_lg && !rst;
      tick();
    end
    rst = 0; f_req = 0; l_req = 0; boot_done = 0;
  endtask

  initial begin
    logic [31:0] v;
    for (int i = 0; i < WORDS; i++) begin
      v = $urandom();
      sram[i]    = v;
      ref_mem[i] = v;
    end
    m_wait = 0; m_boot = BOOT_LOCK;
    e_fg = 0; e_lg = 0; e_fv = 0; e_fe = 0; e_lv = 0; e_fd = '0; e_ld = '0;
    f_addr = '0; l_addr = '0; l_wdata = '0; l_we = 0;
    test_reset();
    test_boot_lock();
    test_starvation();
    test_bad_access();
    test_back_to_back();
    test_reset_mid_read();
    test_loader_read();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Shares one synchronous single-port instruction SRAM between the core fetch port and the program-loader port. Sits between the RV32I fetch stage, the loader, and the instruction SRAM. Fetch has fixed priority, and a starvation counter guarantees loader progress. An optional boot lock holds fetch off until the loader signals that the program image is complete.

## Interface
- ADDR_W, 10: SRAM word-address width (2^ADDR_W words).
- MAX_WAIT, 4: consecutive denied loader cycles before the loader is forced a grant; range 1..15.

- clk  in  1  clock, rising edge
- rst  in  1  reset; synchronous, active-high
- f_req  in  1  fetch request (read)
- f_addr  in  32  fetch byte address
- f_gnt  out  1  fetch granted this cycle (combinational)
- f_rvalid  out  1  fetch data valid
- f_rdata  out  32  fetch instruction
- f_err  out  1  qualifies f_rvalid; misaligned or out-of-range access
- l_req  in  1  loader request
- l_we  in  1  loader write (1) / read (0)
- l_addr  in  32  loader byte address
- l_wdata  in  32  loader write data
- l_gnt  out  1  loader granted this cycle (combinational)
- l_rvalid  out  1  loader read data valid
- l_rdata  out  32  loader read data
- boot_done  in  1  loader image complete
- mem_en  out  1  SRAM enable
- mem_we  out  1  SRAM write enable
- mem_addr  out  ADDR_W  SRAM word address
- mem_wdata  out  32  SRAM write data
- mem_rdata  in  32  SRAM read data, valid 1 cycle after mem_en with mem_we=0

## Operation
- States: BOOT and RUN. Reset state is BOOT when IMEM_BOOT_LOCK_EN is defined, otherwise RUN.
- BOOT:
  - f_gnt=0.
  - l_gnt=l_req.
  - boot_done=1 moves to RUN on the next edge. A loader access in that same cycle still completes.
- RUN:
  - At most one grant per cycle.
  - Default: f_gnt=f_req, and l_gnt=l_req&!f_req.
  - Override: when wait_cnt==MAX_WAIT and l_req=1, l_gnt=1 and f_gnt=0.
- wait_cnt (4 bits):
  - Increments when l_req=1 and l_gnt=0.
  - Clears on l_gnt or l_req=0.
  - Saturates at MAX_WAIT.
- Address decoding:
  - Word address is addr[ADDR_W+1:2].
  - Out of range: addr[31:ADDR_W+2]!=0.
  - Misaligned: addr[1:0]!=0.
- Bad fetch (misaligned or out of range):
  - Granted normally, but mem_en=0.
  - Next cycle: f_rvalid=1, f_rdata=32'h00000013 (NOP), f_err=1.
- Bad loader access:
  - Granted, mem_en=0, write dropped.
  - A bad read returns l_rvalid=1 with l_rdata=0.
- Loader writes are acknowledged by l_gnt only. l_rvalid is not asserted for writes.
- Memory drive: mem_en, mem_we, mem_addr and mem_wdata are combinational from the granted request. They are 0 when nothing is granted.

## Timing
- Read latency: grant in cycle N, rvalid and data in cycle N+1, single cycle only. The requester may issue back-to-back, for a throughput of 1 per cycle.
- Requesters hold req/addr stable until they see their gnt. A request without gnt is retried the next cycle.
- f_rvalid and l_rvalid are never asserted in the same cycle.
- Write in cycle N followed by a read of the same address in N+1 returns the new data.
- Reset values:
  - f_rvalid=0, l_rvalid=0, f_rdata=0, l_rdata=0, f_err=0.
  - wait_cnt=0.
  - State per configuration.
  - gnt and mem_* forced to 0 while rst=1.
- Reset mid-operation: a response pending from a grant in the reset cycle is discarded. The rvalid outputs are 0 in the cycle after rst is sampled.
- boot_done is ignored in RUN, and ignored entirely when the macro is undefined.

## Configuration
- IMEM_BOOT_LOCK_EN defined:
  - Reset enters BOOT; fetch is stalled until boot_done.
  - In BOOT the loader has exclusive access.
- Undefined:
  - Reset enters RUN; the BOOT state logic is not compiled.
  - Fetch is served from the first cycle after reset.

## Structure
- Package imem_pkg holds:
  - state enum {BOOT, RUN};
  - the RV32I NOP constant 32'h00000013;
  - the default ADDR_W.
- Natural sub-module: imem_starve_cnt, which implements wait_cnt and exposes force_l = (wait_cnt==MAX_WAIT)&l_req.
- The SRAM is a separate instance and is not part of this block.

## Test plan
- Boot lock: reset, f_req=1, loader writes 0xDEADBEEF to 0x10, then boot_done=1 -> f_gnt=0 throughout BOOT. First fetch of 0x10 in RUN returns 0xDEADBEEF one cycle after its grant.
- Starvation (MAX_WAIT=4): f_req held 1 and l_req held 1 -> four fetch grants, then one l_gnt cycle, then fetch grants resume. wait_cnt returns to 0.
- Bad fetches: fetch 0x02 and fetch 0x00001000 (ADDR_W=10) -> mem_en=0. Next cycle: f_rvalid=1, f_rdata=0x00000013, f_err=1.
- Back-to-back fetch 0x0, 0x4, 0x8 -> three consecutive f_rvalid cycles with matching SRAM words, f_err=0.
- Reset mid-read: fetch granted in the same cycle that rst=1 is sampled -> f_rvalid=0 next cycle, and all outputs at their reset values.
- Loader read of 0x20 while f_req=0 -> l_gnt same cycle, l_rvalid with the word one cycle later, f_rvalid=0.
